shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit storage register, a bank of synchronous-reset D flip-flops.
- Up to NREQ requesters compete to load the register; each accepted write is acknowledged back to its owner.
- Sits between independent producer blocks and a single shared state/config register read by downstream logic.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, width of the shared register and of each requester data lane
SRCW, $clog2(NREQ), localparam: width of requester index

Ports:
clk    input   1           clock, all logic on rising edge
rst    input   1           synchronous, active-high reset
req    input   NREQ        per-requester write request, level, held until ack
din    input   NREQ*WIDTH  packed data lanes; lane i = din[i*WIDTH +: WIDTH]
gnt    output  NREQ        registered one-hot grant, high during WRITE state only
ack    output  NREQ        one-cycle pulse: write from requester i committed
q      output  WIDTH       shared register contents
q_src  output  SRCW        index of requester that performed the last committed write
busy   output  1           high while state = WRITE

Behaviour:
- Reset (rst=1 at a clk edge): q=0, q_src=0, gnt=0, ack=0, busy=0, state=ARB, rr pointer ptr=NREQ-1 (requester 0 has top priority after reset). Reset dominates every other event, including mid-WRITE; no ack is issued for an interrupted write.
- States: ARB, WRITE.
- ARB:
  - ack=0, gnt=0.
  - If req!=0, select the first asserted req searching ptr+1, ptr+2, ... modulo NREQ.
  - Next cycle: gnt=onehot(sel), busy=1, state=WRITE.
  - If req==0, remain in ARB.
- WRITE (one cycle):
  - If req[sel]=1 at this edge: q <= lane sel of din, q_src <= sel, ack[sel] pulses next cycle, ptr <= sel.
  - If req[sel]=0 (requester withdrew): abort. q, q_src and ptr unchanged, no ack.
  - Either way: next state=ARB, gnt=0, busy=0.
- Latency: req asserted in cycle t with the arbiter idle -> gnt in t+1 -> q updated and ack visible in t+2.
- Throughput: one write per 2 cycles maximum.
- ack is registered, so it coincides with the cycle ARB re-evaluates. A requester must drop req in the ack cycle or it may be re-granted only after other pending requesters (round-robin).
- Data sampled only at the WRITE edge; din of non-granted lanes ignored; din[sel] must be stable from grant to that edge.
- Fairness:
  - ptr advances only on committed writes.
  - With all NREQ requesting continuously, grants rotate 0,1,2,...,NREQ-1,0.
  - No requester waits more than NREQ grants.
- Requests changing during WRITE do not affect the current grant.
- gnt and ack are always one-hot or zero, never multi-hot.
- q holds its value whenever no write commits.

Test Plan:
- Reset: drive random req/din with rst=1 for 3 cycles -> q=0x00, q_src=0, gnt=0, ack=0, busy=0 throughout and on the first cycle after release.
- Single write: req=4'b0100, lane2=0xA5 in cycle t -> gnt=4'b0100 and busy=1 at t+1; q=0xA5, q_src=2, ack=4'b0100 at t+2; ack low at t+3 after req dropped.
- Round-robin: req=4'b1111 held, lanes=0x10,0x11,0x12,0x13 -> q sequence 0x10,0x11,0x12,0x13,0x10 at 2-cycle spacing; ack rotates 0001,0010,0100,1000,0001.
- Priority after reset: req=4'b1010 from reset -> requester 1 granted first (q=lane1), then requester 3; never 3 before 1.
- Abort: req=4'b0001 granted, req[0] dropped during WRITE -> q unchanged (prior 0x5C stays), no ack, ptr unchanged; next req=4'b0011 grants 0 first.
- Reset mid-WRITE: assert rst in the WRITE cycle with lane1=0xFF -> q=0x00, no ack pulse, state ARB, gnt=0 next cycle.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared register.
// One write per two cycles: ARB picks a requester, WRITE commits its lane or aborts if it withdrew.
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int SRCW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [SRCW-1:0]       q_src,
  output logic                  busy
);

  typedef enum logic {ARB, WRITE} state_t;

  state_t          state;
  logic [SRCW-1:0] ptr;
  logic [SRCW-1:0] sel;
  logic [SRCW-1:0] sel_nxt;
  logic [SRCW-1:0] cand;
  logic            found;

  // Search starts just past the last committed writer, wrapping modulo NREQ.
  always_comb begin
    sel_nxt = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = SRCW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        sel_nxt = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= SRCW'(NREQ - 1);
      sel   <= '0;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      q_src <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          ack <= '0;
          if (found) begin
            sel   <= sel_nxt;
            gnt   <= NREQ'(1) << sel_nxt;
            busy  <= 1'b1;
            state <= WRITE;
          end else begin
            gnt <= '0;
          end
        end
        WRITE: begin
          if (req[sel]) begin
            q     <= din[int'(sel)*WIDTH +: WIDTH];
            q_src <= sel;
            ack   <= NREQ'(1) << sel;
            ptr   <= sel;
          end else begin
            ack <= '0;
          end
          gnt   <= '0;
          busy  <= 1'b0;
          state <= ARB;
        end
        default: begin
          state <= ARB;
          gnt   <= '0;
          ack   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
